// File: rtl/jingle_player.sv
`timescale 1ns/1ps
// Streams DEPTH samples from a synchronous jingle memory to a valid/ready sink; JINGLE_PLAYER_LOOP_EN wraps at the end of the table.
// Latency: first sample_valid 3 cycles after start is accepted; one sample per 3 cycles when the sink is always ready.
// Backpressure: sample_data/sample_valid are held until sample_ready; the next fetch is issued only after acceptance.
module jingle_player #(
    parameter int DEPTH = 15168,
    parameter int AW    = 14,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    output logic [AW-1:0] mem_address,
    output logic          mem_chipselect,
    input  logic [DW-1:0] mem_readdata,
    output logic [DW-1:0] sample_data,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        PRESENT
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] addr;

    // The address register drives the memory directly, so it only moves when a fetch is issued.
    assign mem_address = addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            addr           <= '0;
            mem_chipselect <= 1'b0;
            sample_data    <= '0;
            sample_valid   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && stop) begin
                // Abort wins over everything, including a transfer completing on the same edge.
                state          <= IDLE;
                mem_chipselect <= 1'b0;
                sample_valid   <= 1'b0;
                busy           <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            addr           <= '0;
                            mem_chipselect <= 1'b1;
                            busy           <= 1'b1;
                            state          <= FETCH;
                        end
                    end
                    FETCH: begin
                        mem_chipselect <= 1'b0;
                        state          <= WAIT;
                    end
                    WAIT: begin
                        sample_data  <= mem_readdata;
                        sample_valid <= 1'b1;
                        state        <= PRESENT;
                    end
                    PRESENT: begin
                        if (sample_ready) begin
                            sample_valid <= 1'b0;
                            if (addr != LAST) begin
                                addr           <= addr + AW'(1);
                                mem_chipselect <= 1'b1;
                                state          <= FETCH;
                            end else begin
                                done <= 1'b1;
`ifdef JINGLE_PLAYER_LOOP_EN
                                addr           <= '0;
                                mem_chipselect <= 1'b1;
                                state          <= FETCH;
`else
                                busy  <= 1'b0;
                                state <= IDLE;
`endif
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
